// File: rtl/jesd204_tx_link_seq.sv
// JESD204 transmit link sequencer: CGS -> ILAS -> DATA, aligned to LMFC boundaries.
// Optional sync-loss event counter enabled by defining JESD204_TX_SEQ_SYNC_LOSS_CNT_EN.
module jesd204_tx_link_seq #(
   parameter int SYNC_DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       sync,
   input  logic       lmfc_edge,
   input  logic [7:0] cfg_mframes_per_ilas,
   input  logic       cfg_skip_ilas,
   output logic       lane_cgs_enable,
   output logic       ilas_enable,
   output logic [7:0] ilas_mframe_cnt,
   output logic       tx_ready,
   output logic [1:0] status_state,
   output logic [7:0] status_sync_loss_cnt
);

   typedef enum logic [1:0] {
      ST_CGS  = 2'd0,
      ST_ILAS = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   localparam logic [3:0] DEB_LAST = 4'(SYNC_DEBOUNCE - 1);

   state_t     state;
   state_t     state_nxt;
   logic       sync_meta;
   logic       sync_s;
   logic [3:0] low_cnt;
   logic [7:0] mframes_lat;
   logic [7:0] mframes_nxt;
   logic [7:0] cnt_nxt;
   logic       in_link;
   logic       sync_loss;

   assign in_link      = (state == ST_ILAS) || (state == ST_DATA);
   // Loss fires on the edge where the low-counter would reach SYNC_DEBOUNCE.
   assign sync_loss    = in_link && !sync_s && (low_cnt == DEB_LAST);
   assign status_state = state;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = ilas_mframe_cnt;
      mframes_nxt = mframes_lat;
      case (state)
         ST_CGS: begin
            cnt_nxt = 8'd0;
            if (lmfc_edge && sync_s) begin
               mframes_nxt = cfg_mframes_per_ilas;
               state_nxt   = cfg_skip_ilas ? ST_DATA : ST_ILAS;
            end
         end
         ST_ILAS: begin
            if (sync_loss) begin
               state_nxt = ST_CGS;
               cnt_nxt   = 8'd0;
            end else if (lmfc_edge) begin
               if (ilas_mframe_cnt == mframes_lat) begin
                  state_nxt = ST_DATA;
                  cnt_nxt   = 8'd0;
               end else begin
                  cnt_nxt = ilas_mframe_cnt + 8'd1;
               end
            end
         end
         ST_DATA: begin
            cnt_nxt = 8'd0;
            if (sync_loss) state_nxt = ST_CGS;
         end
         default: begin
            state_nxt = ST_CGS;
            cnt_nxt   = 8'd0;
         end
      endcase
   end

   // tx_ready is a plain level qualifier for the datapath, not a valid/ready handshake.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_meta       <= 1'b0;
         sync_s          <= 1'b0;
         low_cnt         <= 4'd0;
         state           <= ST_CGS;
         mframes_lat     <= 8'd0;
         ilas_mframe_cnt <= 8'd0;
         lane_cgs_enable <= 1'b1;
         ilas_enable     <= 1'b0;
         tx_ready        <= 1'b0;
      end else begin
         sync_meta <= sync;
         sync_s    <= sync_meta;
         if (!in_link || sync_s) begin
            low_cnt <= 4'd0;
         end else if (low_cnt != 4'hF) begin
            low_cnt <= low_cnt + 4'd1;
         end
         state           <= state_nxt;
         mframes_lat     <= mframes_nxt;
         ilas_mframe_cnt <= cnt_nxt;
         lane_cgs_enable <= (state_nxt == ST_CGS);
         ilas_enable     <= (state_nxt == ST_ILAS);
         tx_ready        <= (state_nxt == ST_DATA);
      end
   end

`ifdef JESD204_TX_SEQ_SYNC_LOSS_CNT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         status_sync_loss_cnt <= 8'd0;
      end else if (sync_loss && (status_sync_loss_cnt != 8'hFF)) begin
         status_sync_loss_cnt <= status_sync_loss_cnt + 8'd1;
      end
   end
`else
   assign status_sync_loss_cnt = 8'd0;
`endif

endmodule
